// File: rtl/vm2_mpi_ram.sv
// VM2 MPI (Q-bus style) RAM responder: decodes an address window and serves word/byte reads and writes from block RAM.
// Optional reply wait states are built when VM2_MPI_RAM_WAIT_EN is defined (W = WAIT_CYCLES), otherwise W = 0.
module vm2_mpi_ram #(
  parameter logic [15:0] ADDR_BASE   = 16'h0000,
  parameter int          MEM_AW      = 12,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pin_init_n,
  input  logic [15:0] pin_ad_n,
  input  logic        pin_sync_n,
  input  logic        pin_din_n,
  input  logic        pin_dout_n,
  input  logic        pin_wtbt_n,
  output logic [15:0] ad_out_n,
  output logic        ad_oe,
  output logic        pin_rply_n,
  output logic        sel
);

  typedef enum logic [2:0] {
    IDLE, ADDR, SEL, IGN, RD_WAIT, RD_RPLY, WR_WAIT, WR_RPLY
  } state_t;

  state_t state, state_d;

  logic [1:0] sync_r, din_r, dout_r, init_r;
  logic       s_sync, s_din, s_dout, s_init, abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '1;
      din_r  <= '1;
      dout_r <= '1;
      init_r <= '1;
    end else begin
      sync_r <= {sync_r[0], pin_sync_n};
      din_r  <= {din_r[0],  pin_din_n};
      dout_r <= {dout_r[0], pin_dout_n};
      init_r <= {init_r[0], pin_init_n};
    end
  end

  assign s_sync = ~sync_r[1];
  assign s_din  = ~din_r[1];
  assign s_dout = ~dout_r[1];
  assign s_init = ~init_r[1];
  assign abort  = ~s_sync | s_init;

  logic [15:0] addr, addr_d;
  logic [15:0] out_d;
  logic        rply_d, oe_d, sel_d, we, wait_done;
  logic        match;

  assign match = (addr[15:MEM_AW+1] == ADDR_BASE[15:MEM_AW+1]);

`ifdef VM2_MPI_RAM_WAIT_EN
  logic [3:0] wcnt, wcnt_d;
  assign wait_done = (wcnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= '0;
    else        wcnt <= wcnt_d;
  end
`else
  assign wait_done = 1'b1;
`endif

  // Block RAM: the read port tracks the latched address every cycle, so
  // read data is already settled by the time DIN reaches the FSM.
  logic [15:0]       mem [0:(2**MEM_AW)-1];
  logic [15:0]       ram_q;
  logic [MEM_AW-1:0] ram_a;
  logic [15:0]       wdata;
  logic              byte_wr, wr_lo, wr_hi;

  assign ram_a   = addr[MEM_AW:1];
  assign wdata   = ~pin_ad_n;
  assign byte_wr = ~pin_wtbt_n;
  assign wr_lo   = ~byte_wr | ~addr[0];
  assign wr_hi   = ~byte_wr |  addr[0];

  always_ff @(posedge clk) begin
    if (we && wr_lo) mem[ram_a][7:0]  <= wdata[7:0];
    if (we && wr_hi) mem[ram_a][15:8] <= wdata[15:8];
    ram_q <= mem[ram_a];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      pin_rply_n <= 1'b1;
      ad_oe      <= 1'b0;
      ad_out_n   <= '1;
      sel        <= 1'b0;
    end else begin
      state      <= state_d;
      addr       <= addr_d;
      pin_rply_n <= rply_d;
      ad_oe      <= oe_d;
      ad_out_n   <= out_d;
      sel        <= sel_d;
    end
  end

  // WTBT in the address phase is not stored: DOUT is honoured whatever it said.
  always_comb begin
    state_d = state;
    addr_d  = addr;
    rply_d  = pin_rply_n;
    oe_d    = ad_oe;
    out_d   = ad_out_n;
    sel_d   = sel;
    we      = 1'b0;
`ifdef VM2_MPI_RAM_WAIT_EN
    wcnt_d  = wcnt;
`endif
    if (abort) begin
      state_d = IDLE;
      rply_d  = 1'b1;
      oe_d    = 1'b0;
      out_d   = '1;
      sel_d   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          addr_d  = ~pin_ad_n;
          state_d = ADDR;
        end
        ADDR: begin
          if (match) begin
            state_d = SEL;
            sel_d   = 1'b1;
          end else begin
            state_d = IGN;
          end
        end
        IGN: ;
        SEL: begin
          if (s_din) begin
            state_d = RD_WAIT;
            out_d   = ~ram_q;
            oe_d    = 1'b1;
`ifdef VM2_MPI_RAM_WAIT_EN
            wcnt_d  = 4'(WAIT_CYCLES);
`endif
          end else if (s_dout) begin
            state_d = WR_WAIT;
            we      = 1'b1;
`ifdef VM2_MPI_RAM_WAIT_EN
            wcnt_d  = 4'(WAIT_CYCLES);
`endif
          end
        end
        RD_WAIT: begin
          out_d = ~ram_q;
          if (wait_done) begin
            state_d = RD_RPLY;
            rply_d  = 1'b0;
          end
`ifdef VM2_MPI_RAM_WAIT_EN
          else wcnt_d = wcnt - 4'd1;
`endif
        end
        RD_RPLY: begin
          if (!s_din) begin
            state_d = SEL;
            rply_d  = 1'b1;
            oe_d    = 1'b0;
            out_d   = '1;
          end
        end
        WR_WAIT: begin
          if (wait_done) begin
            state_d = WR_RPLY;
            rply_d  = 1'b0;
          end
`ifdef VM2_MPI_RAM_WAIT_EN
          else wcnt_d = wcnt - 4'd1;
`endif
        end
        WR_RPLY: begin
          if (!s_dout) begin
            state_d = SEL;
            rply_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
